spi_slave_regbank: RTL and testbench

Parametrised SPI slave with an internal register bank; successor to the fixed-width NIOS-side SPI slave export. Selectable SPI mode and word width, with separate banks of SPI-writable control registers and fabric-driven status registers. Sits between the top-level SPI pins and fabric logic (PWM, encoder and motor control blocks); the external master, the HPS SPI master or an external MCU, reads and writes words by address.

---
 rtl/spi_slave_pkg.sv | 9 +
 rtl/spi_slave_sync_edge.sv | 23 ++
 rtl/spi_slave_regbank.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_regbank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register bank.
package spi_slave_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam int CMD_W      = 8;
    localparam int ADDR_W     = 7;
    localparam int CMD_RD_BIT = 7;
    localparam logic [ADDR_W-1:0] ERR_CLR_ADDR = 7'h7F;
endpackage

// File: rtl/spi_slave_sync_edge.sv
// 2-flop synchroniser for an asynchronous pin, plus single-cycle edge pulses
// derived from the synchronised level.
module spi_slave_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= {3{INIT}};
        else       sr <= {sr[1:0], din};
    end

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave with SPI-writable control registers and fabric-fed status registers.
// Optional build macro SPI_SLAVE_ERR_CNT_EN adds the err_count abort counter.
module spi_slave_regbank
    import spi_slave_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_WR   = 8,
    parameter int NUM_RD   = 8,
    parameter int SPI_MODE = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_sclk,
    input  logic                     spi_mosi,
    input  logic                     spi_ss_n,
    output logic                     spi_miso,
    output logic [NUM_WR*DATA_W-1:0] regs_out,
    input  logic [NUM_RD*DATA_W-1:0] status_in,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     busy
`ifdef SPI_SLAVE_ERR_CNT_EN
    ,
    output logic [15:0]              err_count
`endif
);
    localparam bit CPOL = ((SPI_MODE >> 1) & 1) != 0;
    localparam bit CPHA = (SPI_MODE & 1) != 0;
    localparam int WR_AW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int RD_AW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [7:0] WR_END   = 8'(NUM_WR);
    localparam logic [7:0] RD_END   = 8'(NUM_WR + NUM_RD);
    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
    localparam logic [5:0] CMD_LAST = 6'(CMD_W - 1);

    logic       sclk_rise, sclk_fall, ss_q, ss_fall, mosi_q;
    logic [3:0] sync_unused;

    spi_slave_sync_edge #(.INIT(CPOL)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .q(sync_unused[0]), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_slave_sync_edge #(.INIT(1'b1)) u_ss (
        .clk(clk), .reset(reset), .din(spi_ss_n),
        .q(ss_q), .rise(sync_unused[1]), .fall(ss_fall)
    );
    spi_slave_sync_edge #(.INIT(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .q(mosi_q), .rise(sync_unused[2]), .fall(sync_unused[3])
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    state_t                         state;
    logic [5:0]                     bit_cnt;
    logic [CMD_W-1:0]               cmd_sr;
    logic [DATA_W-1:0]              data_sr, tx_sr;
    logic                           load_pend, commit_pend;
    logic [1:0]                     arm_pipe;
    logic                           armed;
    logic [NUM_WR-1:0][DATA_W-1:0]  regs;
    logic [NUM_RD-1:0][DATA_W-1:0]  status_arr;

    logic [ADDR_W-1:0] addr, rd_off;
    logic              is_rd, in_wr, in_rd;

    assign regs_out   = regs;
    assign status_arr = status_in;
    assign addr       = cmd_sr[ADDR_W-1:0];
    assign is_rd      = cmd_sr[CMD_RD_BIT];
    assign in_wr      = {1'b0, addr} < WR_END;
    assign in_rd      = !in_wr && ({1'b0, addr} < RD_END);
    assign rd_off     = addr - WR_END[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            tx_sr       <= '0;
            load_pend   <= 1'b0;
            commit_pend <= 1'b0;
            arm_pipe    <= '0;
            armed       <= 1'b0;
            spi_miso    <= 1'b0;
            busy        <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            regs        <= {NUM_WR{RESET_VAL}};
`ifdef SPI_SLAVE_ERR_CNT_EN
            err_count   <= '0;
`endif
        end else begin
            // Only arm once the synchronisers hold real pin values and ss_n is
            // high, so a frame already running at reset release is never joined.
            arm_pipe <= {arm_pipe[0], 1'b1};
            if (arm_pipe[1] && ss_q) armed <= 1'b1;

            load_pend   <= 1'b0;
            commit_pend <= 1'b0;
            wr_strobe   <= 1'b0;

            if (load_pend) begin
                if (!is_rd)     tx_sr <= '0;
                else if (in_wr) tx_sr <= regs[addr[WR_AW-1:0]];
                else if (in_rd) tx_sr <= status_arr[rd_off[RD_AW-1:0]];
                else            tx_sr <= '0;
            end

            if (commit_pend) begin
                if (in_wr) begin
                    regs[addr[WR_AW-1:0]] <= data_sr;
                    wr_strobe             <= 1'b1;
                    wr_addr               <= addr;
                end
`ifdef SPI_SLAVE_ERR_CNT_EN
                else if (addr == ERR_CLR_ADDR) err_count <= '0;
`endif
            end

            if (state != IDLE && ss_q) begin
                state    <= IDLE;
                busy     <= 1'b0;
                spi_miso <= 1'b0;
`ifdef SPI_SLAVE_ERR_CNT_EN
                if (state != DONE && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                        if (ss_fall && armed) begin
                            state <= ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    ADDR: if (sample_edge) begin
                        cmd_sr <= {cmd_sr[CMD_W-2:0], mosi_q};
                        if (bit_cnt == CMD_LAST) begin
                            bit_cnt   <= '0;
                            state     <= DATA;
                            load_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    DATA: begin
                        if (shift_edge) begin
                            spi_miso <= tx_sr[DATA_W-1];
                            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            data_sr <= {data_sr[DATA_W-2:0], mosi_q};
                            if (bit_cnt == LAST_BIT) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                commit_pend <= !is_rd;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    default: spi_miso <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: mode 0 / 32-bit instance and mode 3 / 16-bit instance.
module tb_spi_slave_regbank;
    localparam time HALF = 80ns;

    logic clk = 1'b0, reset = 1'b1;
    logic sclk_a = 1'b0, ss_a = 1'b1, sclk_b = 1'b1, ss_b = 1'b1, mosi = 1'b0;
    logic miso_a, miso_b, strobe_a, strobe_b, busy_a, busy_b;
    logic [6:0] waddr_a, waddr_b;
    logic [255:0] regs_a, status_a = '0, exp_a;
    logic [127:0] regs_b;
    logic [127:0] status_b = '0;
`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [15:0] err_a, err_b;
`endif

    int n_cmp = 0, n_bad = 0;
    int stb_cnt_a = 0, stb_cnt_b = 0;
    logic [6:0] stb_last_a = '0, stb_last_b = '0;

    always #5ns clk = ~clk;

    spi_slave_regbank #(.DATA_W(32), .NUM_WR(8), .NUM_RD(8), .SPI_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .spi_sclk(sclk_a), .spi_mosi(mosi), .spi_ss_n(ss_a),
        .spi_miso(miso_a), .regs_out(regs_a), .status_in(status_a),
        .wr_strobe(strobe_a), .wr_addr(waddr_a), .busy(busy_a)
`ifdef SPI_SLAVE_ERR_CNT_EN
        , .err_count(err_a)
`endif
    );

    spi_slave_regbank #(.DATA_W(16), .NUM_WR(8), .NUM_RD(8), .SPI_MODE(3)) dut_b (
        .clk(clk), .reset(reset), .spi_sclk(sclk_b), .spi_mosi(mosi), .spi_ss_n(ss_b),
        .spi_miso(miso_b), .regs_out(regs_b), .status_in(status_b),
        .wr_strobe(strobe_b), .wr_addr(waddr_b), .busy(busy_b)
`ifdef SPI_SLAVE_ERR_CNT_EN
        , .err_count(err_b)
`endif
    );

    always @(negedge clk) begin
        if (strobe_a) begin stb_cnt_a <= stb_cnt_a + 1; stb_last_a <= waddr_a; end
        if (strobe_b) begin stb_cnt_b <= stb_cnt_b + 1; stb_last_b <= waddr_b; end
    end

    task automatic set_sclk(input bit b, input logic v);
        if (b) sclk_b = v; else sclk_a = v;
    endtask

    // b=0: instance A (CPOL=0, CPHA=0); b=1: instance B (CPOL=1, CPHA=1).
    // tx is left-aligned: bit i of the frame is tx[39-i]; rx likewise.
    task automatic xfer(input bit b, input int nbits, input logic [39:0] tx,
                        input bit release_ss, output logic [39:0] rx);
        rx = '0;
        if (b) ss_b = 1'b0; else ss_a = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!b) begin
                mosi = tx[39-i]; #(HALF);
                set_sclk(b, 1'b1); rx[39-i] = miso_a; #(HALF);
                set_sclk(b, 1'b0);
            end else begin
                set_sclk(b, 1'b0); mosi = tx[39-i]; #(HALF);
                set_sclk(b, 1'b1); rx[39-i] = miso_b; #(HALF);
            end
        end
        #(HALF);
        if (release_ss) begin
            if (b) ss_b = 1'b1; else ss_a = 1'b1;
            #(HALF);
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (miso_a !== 1'b0 || miso_b !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b/%b want 0/0", miso_a, miso_b); end
        n_cmp++; if (strobe_a !== 1'b0 || strobe_b !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b/%b want 0/0", strobe_a, strobe_b); end
        n_cmp++; if (waddr_a !== 7'd0 || waddr_b !== 7'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %h/%h want 0/0", waddr_a, waddr_b); end
        n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_a, busy_b); end
        n_cmp++; if (regs_a !== '0) begin n_bad++; $display("FAIL reset_regs_a: got %h want 0", regs_a); end
        n_cmp++; if (regs_b !== '0) begin n_bad++; $display("FAIL reset_regs_b: got %h want 0", regs_b); end
`ifdef SPI_SLAVE_ERR_CNT_EN
        n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL reset_err: got %h want 0", err_a); end
`endif
    endtask

    task automatic test_write();
        logic [39:0] rx;
        xfer(0, 40, {8'h03, 32'hDEADBEEF}, 1, rx);
        exp_a = '0; exp_a[3*32 +: 32] = 32'hDEADBEEF;
        n_cmp++; if (regs_a[3*32 +: 32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_slot3: got %h want deadbeef", regs_a[3*32 +: 32]); end
        n_cmp++; if (regs_a !== exp_a) begin n_bad++; $display("FAIL wr_other_slots: got %h want %h", regs_a, exp_a); end
        n_cmp++; if (stb_cnt_a !== 1) begin n_bad++; $display("FAIL wr_strobe_count: got %0d want 1", stb_cnt_a); end
        n_cmp++; if (stb_last_a !== 7'd3) begin n_bad++; $display("FAIL wr_addr: got %0d want 3", stb_last_a); end
    endtask

    task automatic test_read();
        logic [39:0] rx;
        xfer(0, 40, {8'h83, 32'h0}, 1, rx);
        n_cmp++; if (rx[39:32] !== 8'h00) begin n_bad++; $display("FAIL rd_cmd_phase_miso: got %h want 00", rx[39:32]); end
        n_cmp++; if (rx[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_ctrl3: got %h want deadbeef", rx[31:0]); end
        status_a[2*32 +: 32] = 32'h12345678;
        fork
            xfer(0, 40, {8'h8A, 32'h0}, 1, rx);
            begin #(HALF * 24); status_a = '0; end
        join
        n_cmp++; if (rx[31:0] !== 32'h12345678) begin n_bad++; $display("FAIL rd_status2: got %h want 12345678", rx[31:0]); end
        n_cmp++; if (stb_cnt_a !== 1) begin n_bad++; $display("FAIL rd_no_strobe: got %0d want 1", stb_cnt_a); end
    endtask

    task automatic test_abort();
        logic [39:0] rx;
        xfer(0, 20, {8'h01, 32'hFFFFFFFF}, 0, rx);
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL abort_busy_mid: got %b want 1", busy_a); end
        ss_a = 1'b1; #(HALF);
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_busy_drop: got %b want 0", busy_a); end
        n_cmp++; if (regs_a !== exp_a) begin n_bad++; $display("FAIL abort_regs: got %h want %h", regs_a, exp_a); end
        n_cmp++; if (stb_cnt_a !== 1) begin n_bad++; $display("FAIL abort_strobe: got %0d want 1", stb_cnt_a); end
`ifdef SPI_SLAVE_ERR_CNT_EN
        n_cmp++; if (err_a !== 16'd1) begin n_bad++; $display("FAIL abort_err_count: got %0d want 1", err_a); end
        xfer(0, 40, {8'h7F, 32'h0}, 1, rx);
        n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL err_clear: got %0d want 0", err_a); end
        n_cmp++; if (stb_cnt_a !== 1 || regs_a !== exp_a) begin n_bad++; $display("FAIL err_clear_side_effect: strobes %0d want 1", stb_cnt_a); end
`endif
    endtask

    task automatic test_out_of_range();
        logic [39:0] rx;
        xfer(0, 40, {8'hD0, 32'h0}, 1, rx);
        n_cmp++; if (rx[31:0] !== 32'h0) begin n_bad++; $display("FAIL oor_read: got %h want 0", rx[31:0]); end
        xfer(0, 40, {8'h50, 32'hFFFFFFFF}, 1, rx);
        n_cmp++; if (stb_cnt_a !== 1) begin n_bad++; $display("FAIL oor_write_strobe: got %0d want 1", stb_cnt_a); end
        n_cmp++; if (regs_a !== exp_a) begin n_bad++; $display("FAIL oor_write_regs: got %h want %h", regs_a, exp_a); end
        xfer(0, 40, {8'h0A, 32'hFFFFFFFF}, 1, rx);
        n_cmp++; if (stb_cnt_a !== 1 || regs_a !== exp_a) begin n_bad++; $display("FAIL status_write: strobes %0d want 1", stb_cnt_a); end
    endtask

    task automatic test_mode3();
        logic [39:0] rx;
        bit miso_seen = 1'b0;
        xfer(1, 24, {8'h00, 16'hA5C3, 16'h0}, 1, rx);
        n_cmp++; if (regs_b[15:0] !== 16'hA5C3) begin n_bad++; $display("FAIL m3_write: got %h want a5c3", regs_b[15:0]); end
        n_cmp++; if (stb_cnt_b !== 1 || stb_last_b !== 7'd0) begin n_bad++; $display("FAIL m3_strobe: got %0d@%0d want 1@0", stb_cnt_b, stb_last_b); end
        xfer(1, 24, {8'h80, 32'h0}, 1, rx);
        n_cmp++; if (rx[31:16] !== 16'hA5C3) begin n_bad++; $display("FAIL m3_read: got %h want a5c3", rx[31:16]); end
        xfer(1, 24, {8'h01, 16'h1234, 16'h0}, 0, rx);
        for (int i = 0; i < 40; i++) begin
            sclk_b = 1'b0; mosi = 1'($urandom_range(0, 1)); #(HALF);
            sclk_b = 1'b1; if (miso_b !== 1'b0) miso_seen = 1'b1; #(HALF);
        end
        ss_b = 1'b1; #(HALF);
        n_cmp++; if (miso_seen !== 1'b0) begin n_bad++; $display("FAIL m3_done_miso: got %b want 0", miso_seen); end
        n_cmp++; if (regs_b[31:16] !== 16'h1234 || regs_b[15:0] !== 16'hA5C3) begin n_bad++; $display("FAIL m3_extra_sclk_regs: got %h want 1234a5c3", regs_b[31:0]); end
        n_cmp++; if (stb_cnt_b !== 2) begin n_bad++; $display("FAIL m3_extra_sclk_strobe: got %0d want 2", stb_cnt_b); end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] rx;
        int base = stb_cnt_a;
        fork
            xfer(0, 40, {8'h02, 32'hCAFEF00D}, 1, rx);
            begin
                #(HALF * 40);
                @(negedge clk) reset = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end
        join
        n_cmp++; if (regs_a !== '0) begin n_bad++; $display("FAIL rstmid_regs: got %h want 0", regs_a); end
        n_cmp++; if (stb_cnt_a !== base) begin n_bad++; $display("FAIL rstmid_strobe: got %0d want %0d", stb_cnt_a, base); end
        xfer(0, 40, {8'h02, 32'hCAFEF00D}, 1, rx);
        n_cmp++; if (regs_a[2*32 +: 32] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rstmid_next_frame: got %h want cafef00d", regs_a[2*32 +: 32]); end
        n_cmp++; if (stb_cnt_a !== base + 1 || stb_last_a !== 7'd2) begin n_bad++; $display("FAIL rstmid_next_strobe: got %0d@%0d want %0d@2", stb_cnt_a, stb_last_a, base + 1); end
`ifdef SPI_SLAVE_ERR_CNT_EN
        n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL rstmid_err: got %0d want 0", err_a); end
`endif
    endtask

    initial begin
        repeat (4) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        test_write();
        test_read();
        test_abort();
        test_out_of_range();
        test_mode3();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
